boot_word_rx: RTL and testbench

BOOT_WORD_RX -- requirements
Module: boot_word_rx

---
 rtl/boot_word_rx.sv | 207 ++++++++++++++++++++
 tb/tb_boot_word_rx.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_word_rx.sv
// boot_word_rx: UART byte receiver that pairs bytes (first byte high) into 16-bit words for a
// 64-entry boot RAM. Define BOOT_RX_PARITY_EN for 8E1 framing with a parity_err pulse.
module boot_word_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        rx,
  input  logic        restart,
  input  logic        word_ready,
  output logic        word_valid,
  output logic [15:0] word_data,
  output logic [5:0]  word_adr,
  output logic        load_done,
  output logic        frame_err,
`ifdef BOOT_RX_PARITY_EN
  output logic        parity_err,
`endif
  output logic        overrun
);

  // Handshake: word_valid rises with word_data/word_adr and holds them steady until a cycle
  // with word_valid && word_ready && ce (acceptance); word_valid drops on the following cycle.

`ifdef BOOT_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  localparam logic [11:0] FULL = 12'(CLKS_PER_BIT);
  localparam logic [11:0] HALF = 12'(CLKS_PER_BIT / 2);

  state_t      state_q;
  logic        rx_s1_q, rx_s2_q;
  logic [11:0] timer_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic        wait_high_q;
  logic        phase_q;
  logic [7:0]  hi_q;
  logic        valid_q;
  logic [15:0] data_q;
  logic [5:0]  adr_q;
  logic        load_done_q, frame_err_q, overrun_q;
`ifdef BOOT_RX_PARITY_EN
  logic        par_bad_q, parity_err_q;
`endif

  logic tick, accept, stop_ok, byte_fire;

  // The timer counts down enabled cycles; reaching 1 marks the bit centre.
  assign tick    = (timer_q == 12'd1);
  assign accept  = valid_q && word_ready && ce;
  assign stop_ok = (state_q == S_STOP) && tick && rx_s2_q;
`ifdef BOOT_RX_PARITY_EN
  assign byte_fire = ce && stop_ok && !par_bad_q;
`else
  assign byte_fire = ce && stop_ok;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      timer_q     <= 12'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      wait_high_q <= 1'b0;
      phase_q     <= 1'b0;
      hi_q        <= 8'd0;
      valid_q     <= 1'b0;
      data_q      <= 16'd0;
      adr_q       <= 6'd0;
      load_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef BOOT_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      load_done_q <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef BOOT_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (ce) begin
        rx_s1_q <= rx;
        rx_s2_q <= rx_s1_q;

        case (state_q)
          S_IDLE: begin
            // After a framing error the line must return high before a new start is trusted.
            if (wait_high_q) begin
              if (rx_s2_q) wait_high_q <= 1'b0;
            end else if (!rx_s2_q) begin
              state_q <= S_START;
              timer_q <= HALF;
            end
          end
          S_START: begin
            if (tick) begin
              if (!rx_s2_q) begin
                state_q   <= S_DATA;
                timer_q   <= FULL;
                bit_cnt_q <= 3'd0;
              end else begin
                state_q <= S_IDLE;
              end
            end else begin
              timer_q <= timer_q - 12'd1;
            end
          end
          S_DATA: begin
            if (tick) begin
              shift_q   <= {rx_s2_q, shift_q[7:1]};
              timer_q   <= FULL;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
`ifdef BOOT_RX_PARITY_EN
                state_q <= S_PARITY;
`else
                state_q <= S_STOP;
`endif
              end
            end else begin
              timer_q <= timer_q - 12'd1;
            end
          end
`ifdef BOOT_RX_PARITY_EN
          S_PARITY: begin
            if (tick) begin
              par_bad_q <= ^{shift_q, rx_s2_q};
              timer_q   <= FULL;
              state_q   <= S_STOP;
            end else begin
              timer_q <= timer_q - 12'd1;
            end
          end
`endif
          S_STOP: begin
            if (tick) begin
              state_q <= S_IDLE;
              if (!rx_s2_q) begin
                frame_err_q <= 1'b1;
                wait_high_q <= 1'b1;
              end
`ifdef BOOT_RX_PARITY_EN
              else if (par_bad_q) begin
                parity_err_q <= 1'b1;
              end
`endif
            end else begin
              timer_q <= timer_q - 12'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase

        if (accept) begin
          valid_q     <= 1'b0;
          adr_q       <= adr_q + 6'd1;
          load_done_q <= (adr_q == 6'd63);
        end

        if (byte_fire) begin
          if (!phase_q) begin
            hi_q    <= shift_q;
            phase_q <= 1'b1;
          end else begin
            phase_q <= 1'b0;
            // A word being accepted this cycle frees the slot for the new one.
            if (valid_q && !accept) begin
              overrun_q <= 1'b1;
            end else begin
              data_q  <= {hi_q, shift_q};
              valid_q <= 1'b1;
            end
          end
        end

        if (restart) begin
          phase_q     <= byte_fire;
          if (byte_fire) hi_q <= shift_q;
          adr_q       <= 6'd0;
          valid_q     <= 1'b0;
          overrun_q   <= 1'b0;
          load_done_q <= 1'b0;
        end
      end
    end
  end

  assign word_valid = valid_q;
  assign word_data  = data_q;
  assign word_adr   = adr_q;
  assign load_done  = load_done_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
`ifdef BOOT_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_boot_word_rx.sv
// Self-checking bench for boot_word_rx: vector table, hand-written corner sequences and a
// random byte stream scored against a byte-to-word reference model (CLKS_PER_BIT = 16).
`timescale 1ns/1ps
module tb_boot_word_rx;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b1;
  logic        rx = 1'b1;
  logic        restart = 1'b0;
  logic        word_ready = 1'b1;
  logic        word_valid;
  logic [15:0] word_data;
  logic [5:0]  word_adr;
  logic        load_done, frame_err, overrun;
`ifdef BOOT_RX_PARITY_EN
  logic        parity_err;
  int          pe_count = 0;
`endif

  boot_word_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .ce(ce), .rx(rx), .restart(restart), .word_ready(word_ready),
    .word_valid(word_valid), .word_data(word_data), .word_adr(word_adr),
    .load_done(load_done), .frame_err(frame_err),
`ifdef BOOT_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun(overrun)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / checker ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard: {adr, data} per accepted word ----------------
  logic [21:0] exp_q[$];
  int   vrun = 0, last_run = 0;
  int   ld_count = 0, fe_count = 0;
  logic prev_fe = 1'b0, prev_acc63 = 1'b0, prev_valid = 1'b0, prev_acc = 1'b0;
  logic [21:0] prev_word = '0;

  always @(negedge clk) begin
    logic acc;
    acc = word_valid && word_ready && ce && !restart;
    if (rst) begin
      if (frame_err) begin
        fe_count++;
        check("frame_err_single_cycle", 32'(prev_fe), 32'd0);
      end
`ifdef BOOT_RX_PARITY_EN
      if (parity_err) pe_count++;
`endif
      if (load_done) begin
        ld_count++;
        check("load_done_after_adr63", 32'(prev_acc63), 32'd1);
      end
      if (word_valid && prev_valid && !prev_acc)
        check("word_stable_while_valid", 32'({word_adr, word_data}), 32'(prev_word));
      if (acc) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got adr %0d data 0x%04h expected no word",
                   word_adr, word_data);
        end else begin
          check("accepted_word", 32'({word_adr, word_data}), 32'(exp_q.pop_front()));
        end
      end
      if (word_valid) vrun++;
      else begin
        if (vrun > 0) last_run = vrun;
        vrun = 0;
      end
    end
    prev_fe    = frame_err;
    prev_acc63 = acc && (word_adr == 6'd63);
    prev_valid = word_valid;
    prev_acc   = acc;
    prev_word  = {word_adr, word_data};
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_en(input int n);
    int c = 0;
    logic en;
    while (c < n) begin
      @(posedge clk);
      en = ce;
      #1;
      if (en) c++;
    end
  endtask

  task automatic send_bits(input logic [11:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      rx = f[i];
      wait_en(CPB);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok, input int gap);
    logic [11:0] f;
`ifdef BOOT_RX_PARITY_EN
    f = {1'b1, stop_ok, ^b, b, 1'b0};
    send_bits(f, 11);
`else
    f = {2'b11, stop_ok, b, 1'b0};
    send_bits(f, 10);
`endif
    rx = 1'b1;
    cycles(gap);
  endtask

`ifdef BOOT_RX_PARITY_EN
  task automatic send_bad_parity(input logic [7:0] b);
    logic [11:0] f;
    f = {1'b1, 1'b1, ~(^b), b, 1'b0};
    send_bits(f, 11);
    rx = 1'b1;
    cycles(4);
  endtask
`endif

  task automatic restart_pulse();
    restart = 1'b1;
    cycles(1);
    restart = 1'b0;
    cycles(1);
  endtask

  task automatic wait_sb(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin cycles(1); t++; end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_valid(input string name);
    int t = 0;
    while (!word_valid && t < 2000) begin cycles(1); t++; end
    check(name, 32'(word_valid), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(word_valid), 32'd0);
    check({tag, "_adr"}, 32'(word_adr), 32'd0);
    check({tag, "_data"}, 32'(word_data), 32'd0);
    check({tag, "_load_done"}, 32'(load_done), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
`ifdef BOOT_RX_PARITY_EN
    check({tag, "_parity_err"}, 32'(parity_err), 32'd0);
`endif
  endtask

  // ---------------- reference model: bytes -> words, address = word count mod 64 ----------------
  int         m_phase = 0, m_adr = 0, m_words = 0, m_ld = 0;
  logic [7:0] m_hi = 8'd0;

  task automatic model_byte(input logic [7:0] b);
    if (m_phase == 0) begin
      m_hi    = b;
      m_phase = 1;
    end else begin
      exp_q.push_back({6'(m_adr), m_hi, b});
      if (m_adr == 63) m_ld++;
      m_adr   = (m_adr + 1) % 64;
      m_words++;
      m_phase = 0;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] data;
    logic [5:0]  adr;
  } vec_t;
  vec_t tbl[5];

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] a, b, c, d;
    int   ld0, fe0, nbad;
    logic rand_done;

    tbl[0] = '{8'hA5, 8'h3C, 16'hA53C, 6'd0};
    tbl[1] = '{8'h00, 8'hFF, 16'h00FF, 6'd1};
    tbl[2] = '{8'hFF, 8'h00, 16'hFF00, 6'd2};
    tbl[3] = '{8'h80, 8'h01, 16'h8001, 6'd3};
    tbl[4] = '{8'h55, 8'hAA, 16'h55AA, 6'd4};

    cycles(4);
    check_reset_outputs("reset");
    rst = 1'b1;
    cycles(3);

    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({tbl[i].adr, tbl[i].data});
      send_byte(tbl[i].b0, 1'b1, 2);
      send_byte(tbl[i].b1, 1'b1, 4);
      wait_sb($sformatf("table%0d_drain", i));
      cycles(3);
      if (i == 0) check("table0_valid_one_cycle", 32'(last_run), 32'd1);
    end

    // restart after a lone byte: phase and address return to zero
    send_byte(8'h11, 1'b1, 4);
    restart_pulse();
    check("restart_adr", 32'(word_adr), 32'd0);
    check("restart_valid", 32'(word_valid), 32'd0);
    exp_q.push_back({6'd0, 16'h2233});
    send_byte(8'h22, 1'b1, 3);
    send_byte(8'h33, 1'b1, 4);
    wait_sb("restart_word_drain");

    // overrun: consumer stalls across three words
    restart_pulse();
    word_ready = 1'b0;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom); d = 8'($urandom);
    send_byte(a, 1'b1, 2);
    send_byte(b, 1'b1, 4);
    wait_valid("overrun_first_valid");
    check("overrun_after_first", 32'(overrun), 32'd0);
    send_byte(c, 1'b1, 2);
    send_byte(d, 1'b1, 4);
    check("overrun_after_second", 32'(overrun), 32'd1);
    send_byte(d, 1'b1, 2);
    send_byte(c, 1'b1, 4);
    check("overrun_retained_data", 32'(word_data), 32'({a, b}));
    check("overrun_retained_adr", 32'(word_adr), 32'd0);
    exp_q.push_back({6'd0, a, b});
    word_ready = 1'b1;
    wait_sb("overrun_drain");
    restart_pulse();
    check("overrun_cleared_by_restart", 32'(overrun), 32'd0);

    // bad stop bit on 0x55: no byte, next two bytes form word 0
    fe0 = fe_count;
    send_byte(8'h55, 1'b0, 4);
    cycles(2);
    check("frame_err_pulses", 32'(fe_count - fe0), 32'd1);
    check("frame_err_no_word", 32'(word_valid), 32'd0);
    a = 8'($urandom); b = 8'($urandom);
    exp_q.push_back({6'd0, a, b});
    send_byte(a, 1'b1, 2);
    send_byte(b, 1'b1, 4);
    wait_sb("frame_err_recover_drain");

    // 5-cycle glitch between the two bytes of a word
    restart_pulse();
    fe0 = fe_count;
    a = 8'($urandom); b = 8'($urandom);
    exp_q.push_back({6'd0, a, b});
    send_byte(a, 1'b1, 4);
    rx = 1'b0;
    cycles(5);
    rx = 1'b1;
    cycles(40);
    check("glitch_no_frame_err", 32'(fe_count - fe0), 32'd0);
    check("glitch_no_word", 32'(word_valid), 32'd0);
    send_byte(b, 1'b1, 4);
    wait_sb("glitch_word_drain");

    // ce low for 50 cycles in the middle of the first byte
    restart_pulse();
    a = 8'($urandom); b = 8'($urandom);
    exp_q.push_back({6'd0, a, b});
    fork
      begin
        send_byte(a, 1'b1, 2);
        send_byte(b, 1'b1, 4);
      end
      begin
        cycles(70);
        ce = 1'b0;
        cycles(50);
        ce = 1'b1;
      end
    join
    wait_sb("ce_stall_drain");

    // reset in the middle of DATA, with a high byte already held
    a = 8'($urandom);
    send_byte(a, 1'b1, 4);
    send_bits({4'hF, 8'h00}, 4);
    rst = 1'b0;
    rx  = 1'b1;
    cycles(3);
    check_reset_outputs("mid_frame_reset");
    rst = 1'b1;
    cycles(30);
    c = 8'($urandom); d = 8'($urandom);
    exp_q.push_back({6'd0, c, d});
    send_byte(c, 1'b1, 2);
    send_byte(d, 1'b1, 4);
    wait_sb("post_reset_drain");

`ifdef BOOT_RX_PARITY_EN
    // wrong parity on 0x01 between the two bytes of a word
    restart_pulse();
    fe0 = pe_count;
    a = 8'($urandom); b = 8'($urandom);
    exp_q.push_back({6'd0, a, b});
    send_byte(a, 1'b1, 4);
    send_bad_parity(8'h01);
    check("parity_err_pulses", 32'(pe_count - fe0), 32'd1);
    send_byte(b, 1'b1, 4);
    wait_sb("parity_recover_drain");
`endif

    // random stream through a full 64-word load and wrap, random ready, random framing errors
    restart_pulse();
    m_phase = 0; m_adr = 0; m_words = 0; m_ld = 0;
    ld0 = ld_count; fe0 = fe_count; nbad = 0;
    rand_done = 1'b0;
    fork
      begin
        while (m_words < 65) begin
          a = 8'($urandom);
          if ($urandom_range(0, 9) == 0) begin
            send_byte(a, 1'b0, int'($urandom_range(0, 20)));
            nbad++;
          end else begin
            model_byte(a);
            send_byte(a, 1'b1, int'($urandom_range(0, 20)));
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          word_ready = 1'($urandom_range(0, 1));
          cycles(1);
        end
      end
    join
    word_ready = 1'b1;
    wait_sb("random_stream_drain");
    cycles(4);
    check("random_load_done_count", 32'(ld_count - ld0), 32'(m_ld));
    check("random_frame_err_count", 32'(fe_count - fe0), 32'(nbad));
    check("random_no_overrun", 32'(overrun), 32'd0);

    check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
